// File: rtl/div_restoring_if.sv
// rtl/div_restoring_if.sv - request/result bundle for the restoring divider
// master drives start/a/b and observes results; slave is the divider side.
interface div_restoring_if;
    logic       start;
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    modport master (
        output start, a, b,
        input  q, r, busy, done, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_restoring.sv
// rtl/div_restoring.sv - 8/4 signed restoring divider, 10-cycle latency
// Optional feature macro: DIV_ZERO_DETECT_EN (early divide-by-zero completion).
module div_restoring (
    input  logic           clk,
    input  logic           rst,
    div_restoring_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [7:0] dvd_q, dvd_d;
    logic [3:0] dvs_q, dvs_d;
    logic [4:0] rem_q, rem_d;
    logic [7:0] iter_q, iter_d;
    logic       neg_q_q, neg_q_d;
    logic       neg_r_q, neg_r_d;
    logic [7:0] q_q, q_d;
    logic [3:0] r_q, r_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef DIV_ZERO_DETECT_EN
    logic       zero_q, zero_d;
    logic       dbz_q, dbz_d;
`endif

    logic [5:0] rem_sh;
    logic [4:0] rem_sub;
    logic       rem_ge;

    // dvd holds the dividend magnitude and fills with quotient bits from the LSB
    always_comb begin
        rem_sh  = {rem_q, dvd_q[7]};
        rem_sub = rem_sh[4:0] - {1'b0, dvs_q};
        rem_ge  = (rem_sh >= {2'b00, dvs_q});
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        iter_d  = iter_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef DIV_ZERO_DETECT_EN
        zero_d  = zero_q;
        dbz_d   = dbz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    busy_d  = 1'b1;
                    dvd_d   = bus.a[7] ? 8'(-bus.a) : bus.a;
                    dvs_d   = bus.b[3] ? 4'(-bus.b) : bus.b;
                    rem_d   = 5'd0;
                    iter_d  = 8'h01;
                    neg_q_d = bus.a[7] ^ bus.b[3];
                    neg_r_d = bus.a[7];
                    state_d = S_CALC;
`ifdef DIV_ZERO_DETECT_EN
                    zero_d  = (bus.b == 4'd0);
                    if (bus.b == 4'd0) begin
                        dvd_d   = 8'hFF;
                        rem_d   = 5'd0;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                dvd_d  = {dvd_q[6:0], rem_ge};
                rem_d  = rem_ge ? rem_sub : rem_sh[4:0];
                iter_d = {iter_q[6:0], 1'b0};
                if (iter_q[7]) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                dvd_d   = neg_q_q ? 8'(-dvd_q) : dvd_q;
                rem_d   = {1'b0, (neg_r_q ? 4'(-rem_q[3:0]) : rem_q[3:0])};
                state_d = S_DONE;
            end
            S_DONE: begin
                q_d     = dvd_q;
                r_d     = rem_q[3:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef DIV_ZERO_DETECT_EN
                dbz_d   = zero_q;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= 8'd0;
            dvs_q   <= 4'd0;
            rem_q   <= 5'd0;
            iter_q  <= 8'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            q_q     <= 8'd0;
            r_q     <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
            zero_q  <= 1'b0;
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            iter_q  <= iter_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_DETECT_EN
            zero_q  <= zero_d;
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_restoring.sv
// tb/tb_div_restoring.sv - directed and exhaustive checks for div_restoring
module tb_div_restoring;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    div_restoring_if bus_if ();

    div_restoring dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_div(input logic [7:0] av, input logic [3:0] bv, input int exp_lat,
                           input logic [7:0] eq, input logic [3:0] er, input logic edz,
                           input bit chk_qr, input bit glitch, input bit chk_hold,
                           input string tag);
        int lat;
        bit seen;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        bus_if.b     = bv;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(bus_if.busy), 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            bus_if.start = glitch && (lat == 2);
            if (glitch) begin
                bus_if.a = 8'd9;
                bus_if.b = 4'd3;
            end
            @(posedge clk);
            #1;
            lat++;
            seen = bus_if.done;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (chk_qr) begin
            check({tag, "_q"}, 32'(bus_if.q), 32'(eq));
            check({tag, "_r"}, 32'(bus_if.r), 32'(er));
        end
        check({tag, "_dz"}, 32'(bus_if.div_by_zero), 32'(edz));
        check({tag, "_busy_end"}, 32'(bus_if.busy), 32'd0);
        if (chk_hold) begin
            repeat (2) begin
                @(posedge clk);
                #1;
                check({tag, "_done_low"}, 32'(bus_if.done), 32'd0);
                check({tag, "_idle"}, 32'(bus_if.busy), 32'd0);
                if (chk_qr) check({tag, "_q_hold"}, 32'(bus_if.q), 32'(eq));
            end
        end
    endtask

    initial begin
        int n_done;
        int qi;
        int ri;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.a = 8'd0;
        bus_if.b = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(bus_if.q), 32'd0);
        check("rst_r", 32'(bus_if.r), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_dz", 32'(bus_if.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_div(8'd100, 4'd7,  10, 8'h0E, 4'h2, 1'b0, 1, 0, 1, "p100_p7");
        run_div(8'h9C,  4'd7,  10, 8'hF2, 4'hE, 1'b0, 1, 0, 1, "m100_p7");
        run_div(8'd100, 4'h9,  10, 8'hF2, 4'h2, 1'b0, 1, 0, 1, "p100_m7");
        run_div(8'h80,  4'hF,  10, 8'h80, 4'h0, 1'b0, 1, 0, 1, "m128_m1");
        run_div(8'h80,  4'h8,  10, 8'h10, 4'h0, 1'b0, 1, 0, 1, "m128_m8");
        run_div(8'h7F,  4'h1,  10, 8'h7F, 4'h0, 1'b0, 1, 0, 0, "p127_p1");
        run_div(8'h80,  4'h1,  10, 8'h80, 4'h0, 1'b0, 1, 0, 0, "m128_p1");
        run_div(8'd7,   4'h8,  10, 8'h00, 4'h7, 1'b0, 1, 0, 0, "p7_m8");
        run_div(8'hFF,  4'h3,  10, 8'h00, 4'hF, 1'b0, 1, 0, 0, "m1_p3");
`ifdef DIV_ZERO_DETECT_EN
        run_div(8'd55,  4'h0,  1,  8'hFF, 4'h0, 1'b1, 1, 0, 1, "dz_on");
`else
        run_div(8'd55,  4'h0,  10, 8'h00, 4'h0, 1'b0, 0, 0, 1, "dz_off");
`endif
        run_div(8'd100, 4'd7,  10, 8'h0E, 4'h2, 1'b0, 1, 1, 1, "ignore_start");

        // abort a division with reset while results of the previous one are visible
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.a = 8'h9C;
        bus_if.b = 4'd7;
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_q", 32'(bus_if.q), 32'd0);
        check("abort_r", 32'(bus_if.r), 32'd0);
        check("abort_busy", 32'(bus_if.busy), 32'd0);
        check("abort_done", 32'(bus_if.done), 32'd0);
        check("abort_dz", 32'(bus_if.div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus_if.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_idle", 32'(bus_if.busy), 32'd0);
        run_div(8'h9C, 4'd7, 10, 8'hF2, 4'hE, 1'b0, 1, 0, 0, "after_rst");

        for (int ai = -128; ai <= 127; ai++) begin
            for (int bi = -8; bi <= 7; bi++) begin
                if (bi != 0) begin
                    qi = ai / bi;
                    ri = ai % bi;
                    run_div(8'(ai), 4'(bi), 10, 8'(qi), 4'(ri), 1'b0, 1, 0, 0,
                            $sformatf("sw_a%0d_b%0d", ai, bi));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_restoring.md
DIV_RESTORING -- requirements
Module: div_restoring

Interface
REQ-001 SHALL provide ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL provide ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL provide ports: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL provide ports: a  input  8  signed dividend (two's complement, full product range of 4x4 multiplier).
REQ-005 SHALL provide ports: b  input  4  signed divisor (two's complement).
REQ-006 SHALL provide ports: q  output  8  signed quotient, registered.
REQ-007 SHALL provide ports: r  output  4  signed remainder, registered.
REQ-008 SHALL provide ports: busy  output  1  high while a division is in progress.
REQ-009 SHALL provide ports: done  output  1  single-cycle pulse, q/r valid.
REQ-010 SHALL provide ports: div_by_zero  output  1  flag, valid with done.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE; DONE returns to IDLE unconditionally.
REQ-012 SHALL, in IDLE with start=1 at edge N, capture a and b, record result signs, load magnitudes, enter CALC, and assert busy from edge N.
REQ-013 SHALL perform exactly 8 restoring shift/subtract iterations in CALC, one per cycle, using a 5-bit unsigned partial remainder and an 8-bit iteration counter/shift register.
REQ-014 SHALL, in FIX, apply sign correction: q negated if sign(a)!=sign(b); r negated if a negative.
REQ-015 SHALL assert done for exactly one cycle, at edge N+10 (10 cycles after start sampling); busy deasserts at the same edge.
REQ-016 SHALL truncate toward zero; |r| < |b|; r takes the sign of a; a = q*b + r when representable.
REQ-017 SHALL treat a=-128, b=-1 as overflow: q=8'h80 (wrap), r=0, no flag.
REQ-018 SHALL handle b=-8 and a=-128 magnitudes correctly (9-bit internal magnitudes where needed).
REQ-019 SHALL ignore start while busy; a and b changes after capture have no effect.
REQ-020 SHALL hold q, r, div_by_zero stable from done until the done of the next division.
REQ-021 SHALL accept start in the cycle after done (back-to-back period 11 cycles).

Reset
REQ-022 SHALL, on rst=1 at any time, including mid-CALC, asynchronously force state IDLE, q=0, r=0, busy=0, done=0, div_by_zero=0.
REQ-023 SHALL abandon any in-flight division on reset; no done pulse is produced for it.
REQ-024 SHALL begin sampling start at the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL define the macro DIV_ZERO_DETECT_EN to enable divide-by-zero detection.
REQ-026 SHALL, with DIV_ZERO_DETECT_EN defined and b=0 sampled: skip CALC/FIX, enter DONE, done at edge N+1, q=8'hFF, r=0, div_by_zero=1.
REQ-027 SHALL, without DIV_ZERO_DETECT_EN: tie div_by_zero to 0; b=0 runs the normal 10-cycle sequence; q/r are the natural restoring-algorithm result (q magnitude 8'hFF before sign fix), unspecified but deterministic.

Verification
REQ-028 SHALL cover: a=100, b=7, start -> done at +10, q=14, r=2.
REQ-029 SHALL cover: a=-100, b=7 -> q=-14 (8'hF2), r=-2 (4'hE); a=100, b=-7 -> q=-14, r=2.
REQ-030 SHALL cover: a=-128, b=-1 -> q=8'h80, r=0, div_by_zero=0; a=-128, b=-8 -> q=16, r=0.
REQ-031 SHALL cover: with DIV_ZERO_DETECT_EN, a=55, b=0 -> done at +1, q=8'hFF, r=0, div_by_zero=1.
REQ-032 SHALL cover: start pulsed at +3 during busy with a=9, b=3 -> ignored; original result delivered at +10; rst=1 at +5 of a new division -> all outputs 0, no done.
REQ-033 SHALL cover: exhaustive sweep a=-128..127, b=-8..7 (b!=0) -> $signed q/r match truncating reference model, back-to-back starts.
